// File: rtl/asg_ft_capture_if.sv
// Control/result bundle between the fixed-target capture block and its controller.
// The master drives triggers, ticks, the signal and ARM/ACK; the slave returns the bitmap and statistics.
interface asg_ft_capture_if #(
  parameter int SIZE  = 3200,
  parameter int IDX_W = 12,
  parameter int CNT_W = 8
);
  logic             RADAR_TRIG_PE;
  logic             USEC_PE;
  logic             SIG_IN;
  logic             ARM;
  logic             ACK;
  logic             BUSY;
  logic             VALID;
  logic [SIZE-1:0]  DATA;
  logic [CNT_W-1:0] PULSE_COUNT;
  logic [IDX_W-1:0] FIRST_IDX;
  logic             FIRST_FOUND;
  logic             RETRIG;

  modport master (
    output RADAR_TRIG_PE, USEC_PE, SIG_IN, ARM, ACK,
    input  BUSY, VALID, DATA, PULSE_COUNT, FIRST_IDX, FIRST_FOUND, RETRIG
  );

  modport slave (
    input  RADAR_TRIG_PE, USEC_PE, SIG_IN, ARM, ACK,
    output BUSY, VALID, DATA, PULSE_COUNT, FIRST_IDX, FIRST_FOUND, RETRIG
  );
endinterface

// File: rtl/asg_ft_capture.sv
// Fixed-target capture: after ARM and a radar trigger, samples SIG_IN once per usec tick into a range bitmap.
// Optional macro ASG_FT_CAPTURE_GLITCH_FILTER_EN adds a 3-tap majority filter after the synchronizer.
module asg_ft_capture #(
  parameter int SIZE  = 3200,
  parameter int IDX_W = 12,
  parameter int CNT_W = 8
) (
  input logic               SYS_CLK,
  input logic               SYS_RST,
  asg_ft_capture_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q;
  logic [SIZE-1:0]  data_q;
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] first_idx_q;
  logic             first_found_q;
  logic             retrig_q;
  logic             prev_q;
  logic             busy_q;
  logic             valid_q;
  logic             sync1_q;
  logic             smp;

`ifdef ASG_FT_CAPTURE_GLITCH_FILTER_EN
  // tap_q[0] is the second synchronizer stage; a level needs two agreeing taps to pass.
  logic [2:0] tap_q;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      sync1_q <= 1'b0;
      tap_q   <= 3'b000;
    end else begin
      sync1_q <= bus.SIG_IN;
      tap_q   <= {tap_q[1:0], sync1_q};
    end
  end

  assign smp = (tap_q[0] & tap_q[1]) | (tap_q[0] & tap_q[2]) | (tap_q[1] & tap_q[2]);
`else
  logic sync2_q;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.SIG_IN;
      sync2_q <= sync1_q;
    end
  end

  assign smp = sync2_q;
`endif

  // A trigger during capture wins over a coincident tick and restarts the sweep.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q       <= IDLE;
      data_q        <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      first_idx_q   <= '0;
      first_found_q <= 1'b0;
      retrig_q      <= 1'b0;
      prev_q        <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ARM) begin
            state_q       <= ARMED;
            busy_q        <= 1'b1;
            data_q        <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            first_idx_q   <= '0;
            first_found_q <= 1'b0;
            retrig_q      <= 1'b0;
          end
        end
        ARMED: begin
          if (bus.RADAR_TRIG_PE) begin
            state_q <= CAPTURE;
            idx_q   <= '0;
            prev_q  <= 1'b0;
          end
        end
        CAPTURE: begin
          if (bus.RADAR_TRIG_PE) begin
            data_q        <= '0;
            count_q       <= '0;
            idx_q         <= '0;
            first_idx_q   <= '0;
            first_found_q <= 1'b0;
            prev_q        <= 1'b0;
            retrig_q      <= 1'b1;
          end else if (bus.USEC_PE) begin
            data_q[idx_q] <= smp;
            prev_q        <= smp;
            if (smp && !prev_q) begin
              if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
              if (!first_found_q) begin
                first_idx_q   <= idx_q;
                first_found_q <= 1'b1;
              end
            end
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.ACK) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BUSY        = busy_q;
  assign bus.VALID       = valid_q;
  assign bus.DATA        = data_q;
  assign bus.PULSE_COUNT = count_q;
  assign bus.FIRST_IDX   = first_idx_q;
  assign bus.FIRST_FOUND = first_found_q;
  assign bus.RETRIG      = retrig_q;
endmodule

// File: doc/asg_ft_capture.md
Name: asg_ft_capture

Overview:
- Receive-side counterpart of the azimuth fixed-target generator.
- After arming, waits for a radar trigger, then samples a 1-bit video/target signal once per microsecond tick into a SIZE-bit range bitmap.
- Presents the bitmap plus pulse statistics with a VALID/ACK handshake.
- Used for loopback self-test of the generated fixed-target pattern and for logging target returns per sweep.

Parameters:
- SIZE, 3200, number of microsecond range slots captured per sweep.
- IDX_W, 12, width of slot index; must satisfy 2^IDX_W >= SIZE.
- CNT_W, 8, width of pulse counter; saturating.

Ports:
- SYS_CLK  input  1  system clock, 100 MHz.
- SYS_RST  input  1  synchronous, active-high reset.
- RADAR_TRIG_PE  input  1  one-cycle radar trigger pulse, SYS_CLK domain.
- USEC_PE  input  1  one-cycle microsecond tick, SYS_CLK domain.
- SIG_IN  input  1  asynchronous signal under capture.
- ARM  input  1  one-cycle request to arm for the next trigger.
- ACK  input  1  one-cycle consumer acknowledge of the result.
- BUSY  output  1  high in ARMED or CAPTURE.
- VALID  output  1  result available (DONE state).
- DATA  output  SIZE  captured bitmap; bit i = sample at slot i.
- PULSE_COUNT  output  CNT_W  number of rising edges in the bitmap.
- FIRST_IDX  output  IDX_W  slot index of the first rising edge.
- FIRST_FOUND  output  1  at least one rising edge seen.
- RETRIG  output  1  sticky; a trigger arrived mid-capture and restarted it.

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, including DATA, the slot index and the previous-sample register.
- Reset is honoured in any state, mid-capture included; partial data is discarded.
- Input conditioning: SIG_IN passes through a 2-flop synchronizer; SMP is the synchronizer output.
- States:
  - IDLE:
    - ARM -> ARMED.
    - Entering ARMED clears DATA, PULSE_COUNT, FIRST_IDX, FIRST_FOUND, RETRIG and idx.
    - RADAR_TRIG_PE, USEC_PE and ACK are ignored.
  - ARMED:
    - RADAR_TRIG_PE -> CAPTURE with idx=0 and prev=0.
    - A USEC_PE in the same cycle as the trigger is not sampled; the first sample is taken at the next USEC_PE.
  - CAPTURE, on each USEC_PE:
    - DATA[idx] <= SMP.
    - If SMP=1 and prev=0: PULSE_COUNT increments, saturating at 2^CNT_W-1. If FIRST_FOUND=0, then FIRST_IDX <= idx and FIRST_FOUND <= 1.
    - prev <= SMP.
    - If idx==SIZE-1, go to DONE; otherwise idx+1.
    - A pulse still high at the last slot counts once; no falling edge is required.
  - CAPTURE, on RADAR_TRIG_PE:
    - Restart: clear DATA, counters and FIRST_*; set idx=0, prev=0; RETRIG <= 1 (sticky until the next ARM or reset).
    - A USEC_PE in the same cycle is not sampled.
  - DONE:
    - VALID=1; DATA and statistics are held stable.
    - ACK -> IDLE; VALID drops the next cycle and the outputs keep their values until the next ARM.
    - RADAR_TRIG_PE and ARM are ignored.
- Latency:
  - VALID rises the cycle after the SIZE-th sample is registered.
  - SIG_IN to SMP is 2 SYS_CLK cycles; edges closer than 3 cycles before USEC_PE may land in either slot.
- Simultaneous events:
  - ARM is ignored outside IDLE.
  - ACK is ignored outside DONE.
  - Trigger takes priority over USEC_PE in the same cycle.
- Width rule: idx never exceeds SIZE-1; no wrap-around within a capture.

Optional Feature:
- Macro: ASG_FT_CAPTURE_GLITCH_FILTER_EN.
- Defined: a 3-tap majority filter, clocked at SYS_CLK, follows the synchronizer. SMP is majority(s[0],s[1],s[2]). SIG_IN to SMP latency becomes 3 cycles, and single-cycle glitches are rejected. Filter taps reset to 0.
- Undefined: SMP is the raw synchronizer output with 2-cycle latency.

Test Plan:
- Pattern loopback:
  - Stimulus: SIZE=3200, ARM, trigger, SIG_IN driven high for 3 ticks starting at slots 100, 500, …, 2900.
  - Required response: DATA has exactly bits [102:100], [502:500], …, [2902:2900] set; PULSE_COUNT=8; FIRST_IDX=100; FIRST_FOUND=1; RETRIG=0; VALID after slot 3199.
- Boundaries:
  - Stimulus: SIZE=16, SIG_IN high at slots 0 and 15 only.
  - Required response: DATA=16'h8001; PULSE_COUNT=2; FIRST_IDX=0.
- Retrigger:
  - Stimulus: SIZE=16, ARM, trigger, high at slot 3, second trigger after slot 5, high at slot 7 of the new sweep.
  - Required response: DATA=16'h0080; PULSE_COUNT=1; FIRST_IDX=7; RETRIG=1.
- Handshake and ignores:
  - Stimulus: trigger in IDLE; ARM in DONE; ACK in CAPTURE.
  - Required response: no state change in any case. ACK in DONE drops VALID within 1 cycle; DATA is held.
- Trigger/tick collision:
  - Stimulus: RADAR_TRIG_PE and USEC_PE in the same cycle while ARMED, SIG_IN=1 constant.
  - Required response: slot 0 is filled at the following tick; DATA all ones; PULSE_COUNT=1; FIRST_IDX=0.
- Reset mid-capture and saturation:
  - Stimulus: SYS_RST at slot 8.
  - Required response: all outputs 0, state IDLE.
  - Stimulus: CNT_W=2 with SIG_IN alternating 1/0 per slot, SIZE=16.
  - Required response: PULSE_COUNT=3 (saturated).
  - Stimulus (macro defined): a 1-cycle SIG_IN glitch.
  - Required response: DATA=0.
